// File: rtl/imem_loader_pkg.sv
// Shared types, constants and helpers for the instruction-memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_LO = 3'd1,
      LEN_HI = 3'd2,
      DATA   = 3'd3,
      WR     = 3'd4,
      CK     = 3'd5,
      FIN    = 3'd6
   } state_e;

   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_W          = 16;

   // Bit count of value; 2048 -> 12 so the address counter can hold MEM_DEPTH itself.
   function automatic int clogb2(input int value);
      int n;
      n = 0;
      for (int v = value; v > 0; v = v >> 1) begin
         n = n + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/imem_loader_asm.sv
// Byte-to-word assembler: little-endian shift-in with a byte index counter.
// Optional 8-bit running sum of data bytes when IMEM_LOADER_CKSUM_EN is defined.
module imem_loader_asm
   import imem_loader_pkg::*;
#(
   parameter int INSTR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr_i,
   input  logic                   byte_en_i,
   input  logic [7:0]             byte_i,
   output logic                   last_o,
   output logic [INSTR_WIDTH-1:0] word_o
`ifdef IMEM_LOADER_CKSUM_EN
   ,
   output logic [7:0]             sum_o
`endif
);

   logic [1:0]             idx_q, idx_d;
   logic [INSTR_WIDTH-9:0] shift_q, shift_d;

   always_comb begin
      idx_d   = idx_q;
      shift_d = shift_q;
      if (clr_i) begin
         idx_d = 2'd0;
      end else if (byte_en_i) begin
         idx_d   = idx_q + 2'd1;
         shift_d = {byte_i, shift_q[INSTR_WIDTH-9:8]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= 2'd0;
         shift_q <= '0;
      end else begin
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   // The word is complete while its final byte is on the bus.
   assign last_o = (idx_q == 2'(BYTES_PER_WORD - 1));
   assign word_o = {byte_i, shift_q};

`ifdef IMEM_LOADER_CKSUM_EN
   logic [7:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clr_i) begin
         sum_d = 8'h00;
      end else if (byte_en_i) begin
         sum_d = sum_q + byte_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= 8'h00;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;
`endif

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: length header + little-endian words -> imem write port.
// Define IMEM_LOADER_CKSUM_EN to require a trailing checksum byte.
//
//   state  | meaning
//   IDLE   | waiting for i_load_start, stream not accepted
//   LEN_LO | accept length low byte
//   LEN_HI | accept length high byte, range check
//   DATA   | accept instruction bytes
//   WR     | one-cycle imem write of the assembled word
//   CK     | accept checksum byte (checksum build only)
//   FIN    | release the core, flag completion
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int INSTR_WIDTH = 32,
   parameter int MEM_DEPTH   = 2048,
   parameter int MEM_DEPTH_W = clogb2(MEM_DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_load_start,
   input  logic                   i_byte_valid,
   input  logic [7:0]             i_byte_data,
   output logic                   o_byte_ready,
   output logic                   o_instr_wena,
   output logic [MEM_DEPTH_W-1:0] o_instr_waddra,
   output logic [INSTR_WIDTH-1:0] o_instr_dina,
   output logic                   o_cpu_hold,
   output logic                   o_load_done,
   output logic                   o_load_err
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MEM_DEPTH);
`ifdef IMEM_LOADER_CKSUM_EN
   localparam state_e AFTER_LAST = CK;
`else
   localparam state_e AFTER_LAST = FIN;
`endif

   state_e                 state_q, state_d;
   logic [7:0]             len_lo_q, len_lo_d;
   logic [MEM_DEPTH_W-1:0] rem_q, rem_d;
   logic [MEM_DEPTH_W-1:0] addr_q, addr_d;
   logic [MEM_DEPTH_W-1:0] waddr_q, waddr_d;
   logic [INSTR_WIDTH-1:0] dina_q, dina_d;
   logic                   wena_q, wena_d;
   logic                   hold_q, hold_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic                   ready;
   logic                   byte_acc;
   logic                   asm_clr;
   logic                   asm_en;
   logic                   asm_last;
   logic [INSTR_WIDTH-1:0] asm_word;
   logic [LEN_W-1:0]       len_full;
`ifdef IMEM_LOADER_CKSUM_EN
   logic [7:0]             asm_sum;
`endif

   always_comb begin
      ready = 1'b0;
      case (state_q)
         LEN_LO, LEN_HI, DATA: ready = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
         CK:                   ready = 1'b1;
`endif
         default:              ready = 1'b0;
      endcase
   end

   assign byte_acc = i_byte_valid && ready;
   assign asm_en   = byte_acc && (state_q == DATA);
   assign len_full = {i_byte_data, len_lo_q};

   imem_loader_asm #(
      .INSTR_WIDTH(INSTR_WIDTH)
   ) u_asm (
      .clk       (clk),
      .rst_n     (rst),
      .clr_i     (asm_clr),
      .byte_en_i (asm_en),
      .byte_i    (i_byte_data),
      .last_o    (asm_last),
      .word_o    (asm_word)
`ifdef IMEM_LOADER_CKSUM_EN
      ,
      .sum_o     (asm_sum)
`endif
   );

   always_comb begin
      state_d  = state_q;
      len_lo_d = len_lo_q;
      rem_d    = rem_q;
      addr_d   = addr_q;
      waddr_d  = waddr_q;
      dina_d   = dina_q;
      wena_d   = 1'b0;
      hold_d   = hold_q;
      done_d   = done_q;
      err_d    = err_q;
      asm_clr  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_load_start) begin
               state_d = LEN_LO;
               done_d  = 1'b0;
               err_d   = 1'b0;
               hold_d  = 1'b1;
               addr_d  = '0;
               asm_clr = 1'b1;
            end
         end
         LEN_LO: begin
            if (byte_acc) begin
               len_lo_d = i_byte_data;
               state_d  = LEN_HI;
            end
         end
         LEN_HI: begin
            if (byte_acc) begin
               if (len_full > MAX_LEN) begin
                  err_d   = 1'b1;
                  state_d = FIN;
               end else if (len_full == '0) begin
                  state_d = AFTER_LAST;
               end else begin
                  rem_d   = len_full[MEM_DEPTH_W-1:0];
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (byte_acc && asm_last) begin
               waddr_d = addr_q;
               dina_d  = asm_word;
               wena_d  = 1'b1;
               state_d = WR;
            end
         end
         WR: begin
            // rem_q counts words still owed, including the one being written now
            addr_d  = addr_q + MEM_DEPTH_W'(1);
            rem_d   = rem_q - MEM_DEPTH_W'(1);
            state_d = (rem_q == MEM_DEPTH_W'(1)) ? AFTER_LAST : DATA;
         end
`ifdef IMEM_LOADER_CKSUM_EN
         CK: begin
            if (byte_acc) begin
               if (8'(asm_sum + i_byte_data) != 8'h00) begin
                  err_d = 1'b1;
               end
               state_d = FIN;
            end
         end
`endif
         FIN: begin
            hold_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         len_lo_q <= 8'h00;
         rem_q    <= '0;
         addr_q   <= '0;
         waddr_q  <= '0;
         dina_q   <= '0;
         wena_q   <= 1'b0;
         hold_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_lo_q <= len_lo_d;
         rem_q    <= rem_d;
         addr_q   <= addr_d;
         waddr_q  <= waddr_d;
         dina_q   <= dina_d;
         wena_q   <= wena_d;
         hold_q   <= hold_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign o_byte_ready   = ready;
   assign o_instr_wena   = wena_q;
   assign o_instr_waddra = waddr_q;
   assign o_instr_dina   = dina_q;
   assign o_cpu_hold     = hold_q;
   assign o_load_done    = done_q;
   assign o_load_err     = err_q;

endmodule
